score_display_ctrl: RTL and testbench
=====================================

# score_display_ctrl

Sequential multi-digit binary-to-decimal display controller. It converts a `WIDTH`-bit unsigned value into `DIGITS` decimal digits using a shift-and-add-3 (double-dabble) engine, one bit per clock. It drives `DIGITS` seven-segment patterns with optional leading-zero blanking and overflow indication. It sits between game logic (score/timer counters) and the board HEX displays, and supersedes the single-digit combinational decoder.

## Interface
- `WIDTH`, 14: bit width of `value`; legal range ≥ 4.
- `DIGITS`, 4: number of decimal digits and displays driven; legal range ≥ 1.
- `ACTIVE_LOW`, 0: 1 inverts every segment bit at the output register.
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the `clock` rising edge.
- `start` in 1: single-cycle request to convert `value`.
- `value` in `WIDTH`: unsigned binary to display; sampled only when `start` is accepted.
- `blank_lz` in 1: leading-zero blanking mode; sampled with `value`.
- `enable` in 1: display enable. When low, all displays show blank; the internal frame is retained.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse when a new frame is committed to `hex`.
- `overflow` out 1: high while the committed frame represents a value > 10^DIGITS − 1.
- `hex` out `7*DIGITS`: segment patterns. `hex[7k+6:7k]` is digit k, where k=0 is the least significant digit. Bit order within a digit is g f e d c b a.

## Operation
- Segment encoding (active-high form, g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - BLANK=0000000, DASH=1000000
- States:
  - IDLE: `start`=1 → latch `value` into shift register, latch `blank_lz`, clear BCD register, load bit counter = `WIDTH`, set `overflow_pending` = (`value` > 10^DIGITS − 1), go to SHIFT.
  - SHIFT: each cycle, every BCD nibble ≥ 5 gets +3. Then {BCD, shift} shifts left by 1 and the counter decrements. When the counter reaches 1 during this cycle, go to COMMIT. SHIFT lasts exactly `WIDTH` cycles.
  - COMMIT: encode the nibbles into the frame register, update `overflow`, pulse `done`, return to IDLE.
- Blanking: with `blank_lz`=1, digits above the most significant nonzero digit are BLANK. Digit 0 is never blanked, so value 0 shows "0".
- Overflow frame: every digit shows DASH and `blank_lz` is ignored. The BCD register is 4*`DIGITS` bits, so its overflowed content is discarded.
- `start` while `busy`=1 is ignored; there is no queueing.
- Frame output: `hex` = `enable` ? frame : BLANK on all digits, then XOR with all-ones if `ACTIVE_LOW`=1. This path is registered: `hex` reflects `enable` one cycle after `enable` changes.
- Nibble values 10–15 cannot reach the encoder outside overflow. They encode as BLANK defensively.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `overflow`=0, state=IDLE.
  - Frame = BLANK on all digits; `hex` = all BLANK (all ones if `ACTIVE_LOW`).
- `start` accepted in cycle t:
  - `busy`=1 in cycles t+1 … t+`WIDTH`+1.
  - `done`=1 and new `hex` visible in cycle t+`WIDTH`+2.
  - `busy`=0 in that same cycle.
  - Latency is `WIDTH`+2 cycles (16 at defaults).
- `start` in the cycle `done` is high is accepted, giving back-to-back conversions every `WIDTH`+2 cycles.
- `reset` mid-conversion aborts: next cycle is IDLE, `hex` is BLANK, and no `done` pulse is produced.
- `reset` and `start` asserted together: `reset` wins.
- `value` changing after acceptance has no effect on the frame in flight.
- `hex` holds the previous frame throughout a conversion; there is no flicker.

## Structure
- Package `display_pkg` holds:
  - segment constants `SEG_0`…`SEG_9`, `SEG_BLANK`, `SEG_DASH`;
  - state enum `{IDLE, SHIFT, COMMIT}`;
  - function `pow10(n)` used for the overflow threshold.
- Sub-module `seg7_encode`: purely combinational 4-bit digit plus blank flag → 7-bit pattern, instantiated `DIGITS` times via generate.
- Top level holds the FSM, bit counter (width clog2(`WIDTH`+1)), shift/BCD registers, leading-zero scan, and the output register.

## Test plan
- Defaults, `blank_lz`=0, `enable`=1, start with `value`=1234 → after 16 cycles `done`=1 and `hex` = {SEG_1, SEG_2, SEG_3, SEG_4} (MSD first). `overflow`=0, and `busy` is high for exactly 15 cycles.
- `value`=7, `blank_lz`=1 → `hex` = {BLANK, BLANK, BLANK, SEG_7}. Then `value`=0, `blank_lz`=1 → {BLANK, BLANK, BLANK, SEG_0}.
- `value`=10000 → `overflow`=1 and all four digits show DASH. Then `value`=9999 → all SEG_9 and `overflow`=0.
- Start 1234; pulse `start` with 5678 in cycle t+5; assert `reset` during a second conversion of 5678 → the second `start` is ignored (frame = 1234, single `done`). The reset yields BLANK with no `done`.
- Deassert `enable` after a 4321 frame → `hex` is BLANK one cycle later. Reassert → 4321 restored without a new `start`.
- `ACTIVE_LOW`=1, `DIGITS`=2, `WIDTH`=7, `value`=42 → `hex` = {~SEG_4, ~SEG_2}. `done` arrives 9 cycles after `start`.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the score display controller.
// Segment patterns are active-high, bit order g f e d c b a.
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Request/status bundle between game logic and the display controller.
// Master drives start/value/blank_lz/enable; slave returns busy/done/overflow/hex.
interface score_display_ctrl_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  blank_lz;
  logic                  enable;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [7*DIGITS-1:0]   hex;

  modport master (
    output start, value, blank_lz, enable,
    input  busy, done, overflow, hex
  );

  modport slave (
    input  start, value, blank_lz, enable,
    output busy, done, overflow, hex
  );
endinterface

// File: rtl/score_display_ctrl_seg7_encode.sv
// One decimal digit to a seven-segment pattern (g..a, active-high).
// Ports: digit (4b), blank (force BLANK) -> seg (7b). Values 10-15 give BLANK.
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Sequential binary-to-decimal seven-segment controller (double dabble, 1 bit/clk).
// Ports: clock, reset (sync, high), bus (slave: start/value/blank_lz/enable in; busy/done/overflow/hex out).
module score_display_ctrl
  import display_pkg::*;
#(
  parameter int WIDTH      = 14,
  parameter int DIGITS     = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  score_display_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int HW = 7 * DIGITS;
  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;
  localparam logic [HW-1:0] INV = {HW{ACTIVE_LOW}};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]   bcd_q, bcd_d, bcd_adj;
  logic            blz_q, blz_d;
  logic            ovp_q, ovp_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [HW-1:0]   frame_q, frame_d;
  logic [HW-1:0]   hex_q, hex_d;
  logic [HW-1:0]   enc;
  logic [DIGITS-1:0] blank;
  logic            seen;
  logic            busy;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // Add-3 correction on every nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Blank every digit above the most significant nonzero one; digit 0 stays lit.
  always_comb begin
    seen  = 1'b0;
    blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) seen = 1'b1;
      blank[k] = blz_q & ~seen & (k != 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .digit (bcd_q[4*g +: 4]),
      .blank (blank[g]),
      .seg   (enc[7*g +: 7])
    );
  end

  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    blz_d   = blz_q;
    ovp_d   = ovp_q;
    ovf_d   = ovf_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d  = bus.value;
          blz_d = bus.blank_lz;
          bcd_d = '0;
          cnt_d = CW'(WIDTH);
          ovp_d = 64'(bus.value) > LIMIT;
        end
      end
      SHIFT: begin
        {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
        cnt_d = cnt_q - CW'(1);
      end
      COMMIT: begin
        frame_d = ovp_q ? {DIGITS{SEG_DASH}} : enc;
        ovf_d   = ovp_q;
        done_d  = 1'b1;
      end
      default: ;
    endcase
    // Fed from frame_d so a new frame shows in the same cycle as done.
    hex_d = (bus.enable ? frame_d : '0) ^ INV;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      blz_q   <= 1'b0;
      ovp_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      frame_q <= '0;
      hex_q   <= INV;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      blz_q   <= blz_d;
      ovp_q   <= ovp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      frame_q <= frame_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.hex      = hex_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: decimal/segment model checked every cycle
// plus literal expectations; a second small active-low instance.
module tb_score_display_ctrl;

  localparam logic [6:0] TAB [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  score_display_ctrl_if #(.WIDTH(14), .DIGITS(4)) b0 ();
  score_display_ctrl_if #(.WIDTH(7),  .DIGITS(2)) b1 ();

  score_display_ctrl #(
    .WIDTH(14), .DIGITS(4), .ACTIVE_LOW(1'b0)
  ) u0 (
    .clock (clk),
    .reset (rst),
    .bus   (b0)
  );

  score_display_ctrl #(
    .WIDTH(7), .DIGITS(2), .ACTIVE_LOW(1'b1)
  ) u1 (
    .clock (clk),
    .reset (rst),
    .bus   (b1)
  );

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Decimal digits by division, blank above the top nonzero digit.
  function automatic logic [27:0] model_frame(input int v, input bit blz);
    int dg [4];
    int msd;
    logic [27:0] f;
    if (v > 9999) return {4{7'h40}};
    msd = 0;
    f   = '0;
    for (int k = 0; k < 4; k++) begin
      dg[k] = (v / (10 ** k)) % 10;
      if (dg[k] != 0) msd = k;
    end
    for (int k = 0; k < 4; k++)
      f[7*k +: 7] = (blz && k > msd) ? 7'h00 : TAB[dg[k]];
    return f;
  endfunction

  int          m_cnt;
  logic        m_done, m_ovf, m_pend_ovf;
  logic [27:0] m_frame, m_pend, m_hex;

  // Model: a conversion occupies 15 busy cycles, then commits.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt   <= 0;
      m_done  <= 1'b0;
      m_ovf   <= 1'b0;
      m_frame <= '0;
      m_hex   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (b0.start) begin
          m_cnt      <= 15;
          m_pend     <= model_frame(int'(b0.value), b0.blank_lz);
          m_pend_ovf <= int'(b0.value) > 9999;
        end
        m_hex <= b0.enable ? m_frame : '0;
      end else if (m_cnt == 1) begin
        m_cnt   <= 0;
        m_frame <= m_pend;
        m_ovf   <= m_pend_ovf;
        m_done  <= 1'b1;
        m_hex   <= b0.enable ? m_pend : '0;
      end else begin
        m_cnt <= m_cnt - 1;
        m_hex <= b0.enable ? m_frame : '0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_hex",  b0.hex,      m_hex);
      chk("m_done", b0.done,     m_done);
      chk("m_busy", b0.busy,     m_cnt != 0);
      chk("m_ovf",  b0.overflow, m_ovf);
    end
  end

  task automatic conv0(input int v, input bit blz,
                       output int lat, output int bn);
    b0.value    = 14'(v);
    b0.blank_lz = blz;
    b0.start    = 1'b1;
    lat = 0;
    bn  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      b0.start = 1'b0;
      b0.value = ~b0.value;
      if (b0.busy) bn++;
      if (b0.done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) $display("FAIL conv_timeout: got none want done");
  endtask

  int lat, bn, nd;
  logic [27:0] f1234, f4321;
  logic [13:0] f42;

  initial begin
    f1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
    f4321 = {7'h66, 7'h4F, 7'h5B, 7'h06};
    f42   = ~{7'h66, 7'h5B};
    rst = 1'b1;
    b0.start = 1'b0; b0.value = '0;
    b0.blank_lz = 1'b0; b0.enable = 1'b1;
    b1.start = 1'b0; b1.value = '0;
    b1.blank_lz = 1'b0; b1.enable = 1'b1;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_hex",  b0.hex, 28'h0);
    chk("rst_busy", b0.busy, 1'b0);
    chk("rst_done", b0.done, 1'b0);
    chk("rst_ovf",  b0.overflow, 1'b0);
    chk("rst_hex1", b1.hex, 14'h3FFF);
    rst = 1'b0;
    @(negedge clk);

    conv0(1234, 1'b0, lat, bn);
    chk("lat_1234",  lat, 16);
    chk("busy_1234", bn, 15);
    chk("hex_1234",  b0.hex, f1234);
    chk("ovf_1234",  b0.overflow, 1'b0);

    conv0(7, 1'b1, lat, bn);
    chk("lat_b2b", lat, 16);
    chk("hex_7",   b0.hex, {21'h0, 7'h07});
    conv0(0, 1'b1, lat, bn);
    chk("hex_0",   b0.hex, {21'h0, 7'h3F});

    conv0(10000, 1'b1, lat, bn);
    chk("ovf_10000", b0.overflow, 1'b1);
    chk("hex_10000", b0.hex, {4{7'h40}});
    conv0(9999, 1'b0, lat, bn);
    chk("ovf_9999",  b0.overflow, 1'b0);
    chk("hex_9999",  b0.hex, {4{7'h6F}});

    @(negedge clk);
    b0.value = 14'd1234; b0.blank_lz = 1'b0; b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (4) @(negedge clk);
    b0.value = 14'd5678; b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (b0.done) nd++;
    end
    chk("ign_done", nd, 1);
    chk("ign_hex",  b0.hex, f1234);

    b0.value = 14'd5678; b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; b0.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; b0.start = 1'b0;
    chk("abort_busy", b0.busy, 1'b0);
    chk("abort_hex",  b0.hex, 28'h0);
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (b0.done) nd++;
    end
    chk("abort_done", nd, 0);

    conv0(4321, 1'b0, lat, bn);
    chk("hex_4321", b0.hex, f4321);
    b0.enable = 1'b0;
    @(negedge clk);
    chk("en_off", b0.hex, 28'h0);
    b0.enable = 1'b1;
    @(negedge clk);
    chk("en_on",  b0.hex, f4321);

    b1.value = 7'd42; b1.start = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      b1.start = 1'b0;
      if (b1.done) begin
        lat = i;
        break;
      end
    end
    chk("lat_42", lat, 9);
    chk("hex_42", b1.hex, f42);
    chk("ovf_42", b1.overflow, 1'b0);

    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
